// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: state encodings, frame constants
// and small helpers for bit timing and word assembly.
package boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_WRITE,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } boot_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0] HEADER_BYTE = 8'h55;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic int half_bit(input int cpb);
      return cpb / 2;
   endfunction

   // Drops one received byte into its little-endian lane of a 32-bit word.
   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
      logic [31:0] r;
      r = w;
      r[8*idx +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// Single-cycle RAM write port driven by the boot loader and muxed onto the
// core's memory port while the core is held in reset.
interface uart_boot_loader_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   modport master (output mem_we, output mem_addr, output mem_wdata);
   modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit glitch rejection at half-bit,
// mid-bit sampling, one-cycle byte_valid or frame_err pulse per character.
module uart_rx_byte
   import boot_pkg::*;
#(
   parameter int CLKS_PER_BIT = 347
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx_line,
   output logic       o_byte_valid,
   output logic [7:0] o_rx_byte,
   output logic       o_frame_err
);

   localparam int HALF = half_bit(CLKS_PER_BIT);
   localparam int CW   = $clog2(CLKS_PER_BIT + 1);

   logic [1:0]    r_sync;
   logic          r_rx_prev;
   rx_state_t     r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic [2:0]    r_bit_idx, w_bit_idx_next;
   logic [7:0]    r_shift, w_shift_next;
   logic          r_byte_valid, w_byte_valid_next;
   logic          r_frame_err, w_frame_err_next;
   logic          w_rx;

   assign w_rx         = r_sync[1];
   assign o_byte_valid = r_byte_valid;
   assign o_rx_byte    = r_shift;
   assign o_frame_err  = r_frame_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync       <= 2'b11;
         r_rx_prev    <= 1'b1;
         r_state      <= RX_IDLE;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_sync       <= {r_sync[0], i_rx_line};
         r_rx_prev    <= w_rx;
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_bit_idx    <= w_bit_idx_next;
         r_shift      <= w_shift_next;
         r_byte_valid <= w_byte_valid_next;
         r_frame_err  <= w_frame_err_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt + 1'b1;
      w_bit_idx_next    = r_bit_idx;
      w_shift_next      = r_shift;
      w_byte_valid_next = 1'b0;
      w_frame_err_next  = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_cnt_next = '0;
            if (r_rx_prev && !w_rx) w_state_next = RX_START;
         end
         RX_START: begin
            // A low pulse shorter than half a bit is treated as noise.
            if (r_cnt == CW'(HALF - 1)) begin
               w_cnt_next     = '0;
               w_bit_idx_next = '0;
               w_state_next   = w_rx ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
               w_cnt_next     = '0;
               w_shift_next   = {w_rx, r_shift[7:1]};
               w_bit_idx_next = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
               w_cnt_next        = '0;
               w_byte_valid_next = w_rx;
               w_frame_err_next  = !w_rx;
               w_state_next      = RX_IDLE;
            end
         end
         default: w_state_next = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial program loader: receives 0x55/LEN/data/CHK frames, writes each word to
// RAM with a single-cycle strobe, then releases the core from reset.
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int                    CLK_FREQ     = 40_000_000,
   parameter int                    BAUD         = 115200,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    MAX_WORDS    = 1024,
   parameter int                    TIMEOUT_CLKS = 4_000_000
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_rx_line,
   uart_boot_loader_if.master  bus,
   output logic                o_core_rst,
   output logic                o_load_done,
   output logic                o_load_err,
   output logic [15:0]         o_word_cnt
);

   localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);
   localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CLKS);

   logic                  w_rx_valid, w_rx_err;
   logic [7:0]            w_rx_byte;
   logic                  r_bv, r_fe;
   logic [7:0]            r_byte;
   boot_state_t           r_state, w_state_next;
   logic [15:0]           r_len, r_word_cnt;
   logic [7:0]            r_chk;
   logic [1:0]            r_byte_idx;
   logic [DATA_WIDTH-1:0] r_word;
   logic [31:0]           r_idle_cnt;
   logic                  w_timed, w_expired, w_header;
   logic [15:0]           w_len_in;

   uart_rx_byte #(.CLKS_PER_BIT(clks_per_bit(CLK_FREQ, BAUD))) u_rx (
      .clk          (clk),
      .rst          (rst),
      .i_rx_line    (i_rx_line),
      .o_byte_valid (w_rx_valid),
      .o_rx_byte    (w_rx_byte),
      .o_frame_err  (w_rx_err)
   );

   assign w_timed   = r_state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
   assign w_expired = w_timed && !r_bv && (r_idle_cnt >= TIMEOUT);
   assign w_header  = r_bv && (r_byte == HEADER_BYTE);
   assign w_len_in  = {r_byte, r_len[7:0]};

   // Status is a pure function of state: ERROR persists until the next header, DONE until rst.
   assign o_core_rst    = (r_state != ST_DONE);
   assign o_load_done   = (r_state == ST_DONE);
   assign o_load_err    = (r_state == ST_ERROR);
   assign o_word_cnt    = r_word_cnt;
   assign bus.mem_we    = (r_state == ST_WRITE);
   assign bus.mem_addr  = BASE_ADDR + ADDR_WIDTH'({r_word_cnt, 2'b00});
   assign bus.mem_wdata = r_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_header) w_state_next = ST_LEN_LO;
         ST_LEN_LO: begin
            if (r_fe || w_expired) w_state_next = ST_ERROR;
            else if (r_bv)         w_state_next = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (r_fe || w_expired)   w_state_next = ST_ERROR;
            else if (r_bv) begin
               if (w_len_in > MAX_LEN)  w_state_next = ST_ERROR;
               else if (w_len_in == '0) w_state_next = ST_CHECK;
               else                     w_state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_fe || w_expired)                   w_state_next = ST_ERROR;
            else if (r_bv && r_byte_idx == 2'd3)     w_state_next = ST_WRITE;
         end
         ST_WRITE:  w_state_next = ((r_word_cnt + 16'd1) == r_len) ? ST_CHECK : ST_DATA;
         ST_CHECK: begin
            if (r_fe || w_expired) w_state_next = ST_ERROR;
            else if (r_bv)         w_state_next = (r_byte == r_chk) ? ST_DONE : ST_ERROR;
         end
         ST_DONE:   w_state_next = ST_DONE;
         ST_ERROR:  if (w_header) w_state_next = ST_LEN_LO;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bv       <= 1'b0;
         r_fe       <= 1'b0;
         r_byte     <= '0;
         r_len      <= '0;
         r_chk      <= '0;
         r_byte_idx <= '0;
         r_word     <= '0;
         r_word_cnt <= '0;
         r_idle_cnt <= '0;
      end else begin
         r_bv   <= w_rx_valid;
         r_fe   <= w_rx_err;
         r_byte <= w_rx_byte;
         if (r_bv || !(w_timed || r_state == ST_WRITE)) r_idle_cnt <= '0;
         else                                            r_idle_cnt <= r_idle_cnt + 32'd1;
         case (r_state)
            ST_IDLE, ST_ERROR: begin
               if (w_header) begin
                  r_len      <= '0;
                  r_chk      <= '0;
                  r_byte_idx <= '0;
                  r_word_cnt <= '0;
               end
            end
            ST_LEN_LO: if (r_bv) begin
               r_len[7:0] <= r_byte;
               r_chk      <= r_chk + r_byte;
            end
            ST_LEN_HI: if (r_bv) begin
               r_len[15:8] <= r_byte;
               r_chk       <= r_chk + r_byte;
            end
            ST_DATA: if (r_bv) begin
               r_word     <= put_byte(r_word, r_byte_idx, r_byte);
               r_byte_idx <= r_byte_idx + 2'd1;
               r_chk      <= r_chk + r_byte;
            end
            ST_WRITE: r_word_cnt <= r_word_cnt + 16'd1;
            default: ;
         endcase
      end
   end

endmodule
